// File: rtl/nand_pipe_arbiter.sv
// nand_pipe_arbiter
//   Round-robin sharing of one two-stage registered NAND unit between N_REQ
//   single-bit requesters. Each result returns tagged with its requester ID.
//
//   Ports:
//     clk            rising-edge clock
//     reset          synchronous, active-high reset
//     req_in         per-requester request level, held until granted
//     a_in, b_in     per-requester operands, sampled only in the grant cycle
//     gnt_out        one-hot grant, combinational from req_in and prio_ptr
//     rsp_valid_out  one-cycle pulse per accepted request, two cycles after grant
//     rsp_id_out     requester index owning the result
//     rsp_q_out      !(a & b) of the granted operands
//     rsp_count_out  (only with NAND_ARB_STATS_EN) saturating count of results
//
//   Optional feature macro: NAND_ARB_STATS_EN
module nand_pipe_arbiter #(
   parameter  int N_REQ = 4,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req_in,
   input  logic [N_REQ-1:0] a_in,
   input  logic [N_REQ-1:0] b_in,
   output logic [N_REQ-1:0] gnt_out,
   output logic             rsp_valid_out,
   output logic [ID_W-1:0]  rsp_id_out,
   output logic             rsp_q_out
`ifdef NAND_ARB_STATS_EN
   ,
   output logic [15:0]      rsp_count_out
`endif
);

   logic [ID_W-1:0]  prio_ptr_reg;
   logic [ID_W-1:0]  prio_ptr_next;
   logic [N_REQ-1:0] ptr_mask;
   logic [N_REQ-1:0] masked_req;
   logic [N_REQ-1:0] search_req;
   logic [ID_W-1:0]  gnt_idx;
   logic             grant;
   logic             a_sel;
   logic             b_sel;

   logic             s1_valid_reg;
   logic             s1_a_reg;
   logic             s1_b_reg;
   logic [ID_W-1:0]  s1_id_reg;

   // Requesters at or above the pointer get first chance; when none of them
   // is asking, the search wraps to the lowest requester overall.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign ptr_mask[gi] = (ID_W'(gi) >= prio_ptr_reg);
   end

   always_comb begin
      masked_req = req_in & ptr_mask;
      search_req = (|masked_req) ? masked_req : req_in;
      // Isolate the lowest set bit of the chosen request vector.
      gnt_out    = reset ? '0 : (search_req & (~search_req + N_REQ'(1)));
   end

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_out[i]) begin
            gnt_idx = ID_W'(i);
         end
      end
   end

   assign grant = |gnt_out;
   assign a_sel = |(a_in & gnt_out);
   assign b_sel = |(b_in & gnt_out);

   // Explicit wrap keeps the pointer below N_REQ for non-power-of-two sizes.
   assign prio_ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_ptr_reg  <= '0;
         s1_valid_reg  <= 1'b0;
         s1_a_reg      <= 1'b0;
         s1_b_reg      <= 1'b0;
         s1_id_reg     <= '0;
         rsp_valid_out <= 1'b0;
         rsp_id_out    <= '0;
         rsp_q_out     <= 1'b0;
      end else begin
         s1_valid_reg  <= grant;
         if (grant) begin
            prio_ptr_reg <= prio_ptr_next;
            s1_a_reg     <= a_sel;
            s1_b_reg     <= b_sel;
            s1_id_reg    <= gnt_idx;
         end
         rsp_valid_out <= s1_valid_reg;
         if (s1_valid_reg) begin
            rsp_q_out  <= ~(s1_a_reg & s1_b_reg);
            rsp_id_out <= s1_id_reg;
         end
      end
   end

`ifdef NAND_ARB_STATS_EN
   // Counts on the same edge that raises rsp_valid_out; sticks at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_count_out <= '0;
      end else if (s1_valid_reg && (rsp_count_out != 16'hFFFF)) begin
         rsp_count_out <= rsp_count_out + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_nand_pipe_arbiter.sv
module tb_nand_pipe_arbiter;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] req_in, a_in, b_in;
   logic [N-1:0] gnt_out;
   logic         rsp_valid_out;
   logic [1:0]   rsp_id_out;
   logic         rsp_q_out;
`ifdef NAND_ARB_STATS_EN
   logic [15:0]  rsp_count_out;
`endif

   nand_pipe_arbiter #(.N_REQ(N)) dut (
      .clk(clk), .reset(reset), .req_in(req_in), .a_in(a_in), .b_in(b_in),
      .gnt_out(gnt_out), .rsp_valid_out(rsp_valid_out),
      .rsp_id_out(rsp_id_out), .rsp_q_out(rsp_q_out)
`ifdef NAND_ARB_STATS_EN
      , .rsp_count_out(rsp_count_out)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int       due;
      logic [1:0] id;
      logic     q;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         mdl_ptr = 0;
   logic [1:0] last_id = '0;
   logic       last_q = 1'b0;
   int         mdl_count = 0;
   bit         quiet = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
   task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] a,
                       input logic [N-1:0] b);
      logic [N-1:0] exp_gnt;
      int           g;
      exp_t         e;
      reset  = r;
      req_in = rq;
      a_in   = a;
      b_in   = b;
      @(negedge clk);
      g = -1;
      if (!r) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && rq[(mdl_ptr + k) % N]) g = (mdl_ptr + k) % N;
         end
      end
      exp_gnt = (g >= 0) ? (N'(1) << g) : '0;
      check("gnt", 32'(gnt_out), 32'(exp_gnt));

      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         check("rsp_valid", 32'(rsp_valid_out), 32'd1);
         check("rsp_id", 32'(rsp_id_out), 32'(e.id));
         check("rsp_q", 32'(rsp_q_out), 32'(e.q));
         last_id = e.id;
         last_q  = e.q;
         if (!quiet) $display("cycle %0d: result id=%0d q=%0d (exp id=%0d q=%0d)",
                              cyc, rsp_id_out, rsp_q_out, e.id, e.q);
      end else begin
         check("rsp_valid_idle", 32'(rsp_valid_out), 32'd0);
         check("rsp_id_hold", 32'(rsp_id_out), 32'(last_id));
         check("rsp_q_hold", 32'(rsp_q_out), 32'(last_q));
      end
`ifdef NAND_ARB_STATS_EN
      check("rsp_count", 32'(rsp_count_out), 32'(mdl_count));
`endif

      // Effects of the edge that ends this cycle.
      if (r) begin
         mdl_ptr = 0;
         sb.delete();
         last_id = '0;
         last_q = 1'b0;
         mdl_count = 0;
      end else begin
         if (sb.size() > 0 && sb[0].due == cyc + 1 && mdl_count < 16'hFFFF) mdl_count++;
         if (g >= 0) begin
            e.due = cyc + 2;
            e.id  = 2'(g);
            e.q   = ~(a[g] & b[g]);
            sb.push_back(e);
            mdl_ptr = (g + 1) % N;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0);
   endtask

   initial begin
      reset = 1'b1; req_in = '0; a_in = '0; b_in = '0;
      @(posedge clk);
      #1;
      // Reset then idle.
      for (int i = 0; i < 3; i++) step(1'b1, '0, '0, '0);
      idle(5);
      // Single request, both NAND outcomes.
      step(1'b0, 4'b0100, 4'b0100, 4'b0100);
      idle(3);
      step(1'b0, 4'b0100, 4'b0100, 4'b0000);
      idle(3);
      // Round-robin fairness from a fresh reset.
      step(1'b1, '0, '0, '0);
      for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, 4'($urandom), 4'($urandom));
      idle(3);
      // Pointer skip and wrap, with idle cycles holding the pointer.
      step(1'b0, 4'b1000, 4'b1000, 4'b1000);
      idle(3);
      step(1'b0, 4'b0101, 4'b0001, 4'b0000);
      step(1'b0, 4'b0100, 4'b0100, 4'b0100);
      idle(3);
      // Reset mid-flight: in-flight entries vanish, then 0010 granted at once.
      step(1'b0, 4'b0001, 4'b0001, 4'b0001);
      step(1'b1, 4'b0010, 4'b0010, 4'b0010);
      step(1'b0, 4'b0010, 4'b0010, 4'b0000);
      idle(4);
      // Random traffic.
      for (int i = 0; i < 40; i++) step(1'b0, 4'($urandom), 4'($urandom), 4'($urandom));
      idle(3);
`ifdef NAND_ARB_STATS_EN
      step(1'b1, '0, '0, '0);
      for (int i = 0; i < 20; i++) step(1'b0, 4'b0001, 4'($urandom), 4'($urandom));
      idle(2);
      check("count_20", 32'(rsp_count_out), 32'd20);
      quiet = 1;
      for (int i = 0; i < 65534 - 20; i++) step(1'b0, 4'b1111, '0, '0);
      idle(3);
      check("count_fffe", 32'(rsp_count_out), 32'hFFFE);
      for (int i = 0; i < 3; i++) step(1'b0, 4'b0010, '0, '0);
      idle(4);
      check("count_sat", 32'(rsp_count_out), 32'hFFFF);
      quiet = 0;
`endif
      if (sb.size() != 0) check("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
